// File: rtl/lsu_arbiter.sv
// Two-requester round-robin arbiter in front of a single LSU port.
// Stores complete straight after issue; loads wait for the LSU return or time out.
//   state | meaning
//   IDLE  | no access in flight, arbitrate requests
//   ISSUE | latched access driven to LSU for one cycle
//   WAIT  | load issued, waiting for data return or timeout
//   DONE  | done/err pulse to the granted requester
module lsu_arbiter #(
  parameter logic [31:0] IDLE_ADDR = 32'h0000_F000,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic [3:0]  i_m0_strb,
  input  logic        i_m0_wren,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  input  logic [3:0]  i_m1_strb,
  input  logic        i_m1_wren,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_strb,
  output logic        o_lsu_wren,
  input  logic [31:0] i_ld_data,
  input  logic        i_data_vld,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT down-counter: terminal count 0 marks the last permitted WAIT cycle
  localparam logic [3:0] WAIT_LOAD = 4'(TIMEOUT - 1);

  state_t      state;
  logic        cur_id;
  logic        last_id;
  logic        wren_q;
  logic [3:0]  wait_cnt;
  logic [31:0] lsu_addr_q;
  logic [31:0] st_data_q;
  logic [3:0]  st_strb_q;
  logic        lsu_wren_q;
  logic        busy_q;
  logic [1:0]  done_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        pick_vld;
  logic        pick;
  logic [31:0] pick_addr;
  logic [31:0] pick_wdata;
  logic [3:0]  pick_strb;
  logic        pick_wren;

  always_comb begin
    pick_vld = i_m0_req | i_m1_req;
    pick     = 1'b0;
    if (i_m0_req && i_m1_req) pick = ~last_id;
    else                      pick = i_m1_req;
    pick_addr  = pick ? i_m1_addr  : i_m0_addr;
    pick_wdata = pick ? i_m1_wdata : i_m0_wdata;
    pick_strb  = pick ? i_m1_strb  : i_m0_strb;
    pick_wren  = pick ? i_m1_wren  : i_m0_wren;
  end

  // Grant is decided in the IDLE cycle so the requester sees it at the accepting edge
  assign o_m0_gnt = (state == IDLE) && pick_vld && !pick;
  assign o_m1_gnt = (state == IDLE) && pick_vld && pick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cur_id     <= 1'b0;
      last_id    <= 1'b1;
      wren_q     <= 1'b0;
      wait_cnt   <= '0;
      lsu_addr_q <= IDLE_ADDR;
      st_data_q  <= '0;
      st_strb_q  <= '0;
      lsu_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state      <= ISSUE;
            cur_id     <= pick;
            last_id    <= pick;
            wren_q     <= pick_wren;
            lsu_addr_q <= pick_addr;
            st_data_q  <= pick_wdata;
            st_strb_q  <= pick_strb;
            lsu_wren_q <= pick_wren;
            busy_q     <= 1'b1;
          end
        end
        ISSUE: begin
          lsu_wren_q <= 1'b0;
          st_data_q  <= '0;
          st_strb_q  <= '0;
          if (wren_q) begin
            state          <= DONE;
            lsu_addr_q     <= IDLE_ADDR;
            done_q[cur_id] <= 1'b1;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (i_data_vld) begin
            state          <= DONE;
            lsu_addr_q     <= IDLE_ADDR;
            done_q[cur_id] <= 1'b1;
            if (cur_id) rdata1_q <= i_ld_data;
            else        rdata0_q <= i_ld_data;
          end else if (wait_cnt == '0) begin
            state          <= DONE;
            lsu_addr_q     <= IDLE_ADDR;
            done_q[cur_id] <= 1'b1;
            err_q[cur_id]  <= 1'b1;
            if (cur_id) rdata1_q <= '0;
            else        rdata0_q <= '0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_m0_done  = done_q[0];
  assign o_m1_done  = done_q[1];
  assign o_m0_err   = err_q[0];
  assign o_m1_err   = err_q[1];
  assign o_m0_rdata = rdata0_q;
  assign o_m1_rdata = rdata1_q;
  assign o_lsu_addr = lsu_addr_q;
  assign o_st_data  = st_data_q;
  assign o_st_strb  = st_strb_q;
  assign o_lsu_wren = lsu_wren_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: scoreboarded transactions, round-robin order,
// load timeout, reset abort and stray data-valid handling.
module tb_lsu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_req, i_m1_req;
  logic [31:0] i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata;
  logic [3:0]  i_m0_strb, i_m1_strb;
  logic        i_m0_wren, i_m1_wren;
  logic        o_m0_gnt, o_m1_gnt, o_m0_done, o_m1_done, o_m0_err, o_m1_err;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [31:0] o_lsu_addr, o_st_data;
  logic [3:0]  o_st_strb;
  logic        o_lsu_wren;
  logic [31:0] i_ld_data;
  logic        i_data_vld;
  logic        o_busy;

  lsu_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
    .i_m0_strb(i_m0_strb), .i_m0_wren(i_m0_wren),
    .o_m0_gnt(o_m0_gnt), .o_m0_done(o_m0_done), .o_m0_err(o_m0_err), .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
    .i_m1_strb(i_m1_strb), .i_m1_wren(i_m1_wren),
    .o_m1_gnt(o_m1_gnt), .o_m1_done(o_m1_done), .o_m1_err(o_m1_err), .o_m1_rdata(o_m1_rdata),
    .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_st_strb(o_st_strb),
    .o_lsu_wren(o_lsu_wren), .i_ld_data(i_ld_data), .i_data_vld(i_data_vld), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        wren;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } txn_t;

  txn_t        sb[$];
  int          rr_exp[$];
  logic [31:0] model_rdata [2];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_m0_req = 0; i_m0_addr = 0; i_m0_wdata = 0; i_m0_strb = 0; i_m0_wren = 0;
    i_m1_req = 0; i_m1_addr = 0; i_m1_wdata = 0; i_m1_strb = 0; i_m1_wren = 0;
    i_ld_data = 0; i_data_vld = 0;
  endtask

  task automatic chk_idle_lsu(input string tag);
    chk({tag, "_addr"}, o_lsu_addr, 32'h0000_F000);
    chk({tag, "_wren"}, 32'(o_lsu_wren), 0);
    chk({tag, "_strb"}, 32'(o_st_strb), 0);
    chk({tag, "_data"}, o_st_data, 0);
  endtask

  // Drive one request at the current negedge (DUT in IDLE), check the grant, push the expectation.
  task automatic issue(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic wren, input logic [31:0] ld_ret,
                       input logic to, input int lat);
    txn_t t;
    t.id = id; t.addr = addr; t.wdata = wdata; t.strb = strb; t.wren = wren; t.lat = lat;
    t.err = to;
    t.rdata = wren ? model_rdata[id] : (to ? 32'h0 : ld_ret);
    sb.push_back(t);
    if (id == 0) begin
      i_m0_req = 1; i_m0_addr = addr; i_m0_wdata = wdata; i_m0_strb = strb; i_m0_wren = wren;
    end else begin
      i_m1_req = 1; i_m1_addr = addr; i_m1_wdata = wdata; i_m1_strb = strb; i_m1_wren = wren;
    end
    #1;
    chk("gnt_req", 32'(id ? o_m1_gnt : o_m0_gnt), 1);
    chk("gnt_other", 32'(id ? o_m0_gnt : o_m1_gnt), 0);
  endtask

  // Step until done; return vld with ld_data on cycle vld_at (0 = never); pop and compare on done.
  task automatic wait_done(input int vld_at, input logic [31:0] ld_data, input int max_cyc);
    txn_t t;
    int   lat;
    bit   seen;
    int   did;
    t = sb[0];
    lat = 0;
    seen = 0;
    while (!seen && lat < max_cyc) begin
      cyc();
      lat++;
      if (lat == 1) begin
        i_m0_req = 0; i_m1_req = 0;
        chk("issue_addr", o_lsu_addr, t.addr);
        chk("issue_data", o_st_data, t.wdata);
        chk("issue_strb", 32'(o_st_strb), 32'(t.strb));
        chk("issue_wren", 32'(o_lsu_wren), 32'(t.wren));
        chk("issue_busy", 32'(o_busy), 1);
      end
      if (lat == 2 && !t.wren) begin
        chk("wait_addr", o_lsu_addr, t.addr);
        chk("wait_wren", 32'(o_lsu_wren), 0);
      end
      i_data_vld = (lat == vld_at);
      i_ld_data  = (lat == vld_at) ? ld_data : 32'h0;
      #1;
      seen = o_m0_done | o_m1_done;
    end
    i_data_vld = 0;
    i_ld_data = 0;
    chk("done_seen", 32'(seen), 1);
    if (seen) begin
      t = sb.pop_front();
      did = o_m1_done ? 1 : 0;
      chk("done_onehot", 32'(o_m0_done & o_m1_done), 0);
      chk("done_id", did, t.id);
      chk("done_lat", lat, t.lat);
      chk("done_err", 32'(did ? o_m1_err : o_m0_err), 32'(t.err));
      chk("done_rdata", did ? o_m1_rdata : o_m0_rdata, t.rdata);
      chk("other_rdata", did ? o_m0_rdata : o_m1_rdata, model_rdata[1 - t.id]);
      model_rdata[t.id] = t.rdata;
      chk_idle_lsu("done_lsu");
      cyc();
      #1;
      chk("done_pulse_end", 32'({o_m0_done, o_m1_done}), 0);
      chk("back_idle_busy", 32'(o_busy), 0);
    end
  endtask

  initial begin
    int grants;
    idle_inputs();
    model_rdata[0] = 0; model_rdata[1] = 0;
    i_rst = 1;
    repeat (3) cyc();
    #1;
    chk("rst_gnt", 32'({o_m0_gnt, o_m1_gnt}), 0);
    chk("rst_done", 32'({o_m0_done, o_m1_done, o_m0_err, o_m1_err}), 0);
    chk("rst_rdata0", o_m0_rdata, 0);
    chk("rst_rdata1", o_m1_rdata, 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk_idle_lsu("rst_lsu");
    cyc();
    i_rst = 0;
    cyc();

    // m0 store, then m1 load of the same address with vld in the first WAIT cycle
    issue(0, 32'h2004, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0, 2);
    wait_done(0, 32'h0, 10);
    issue(1, 32'h2004, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    wait_done(2, 32'hDEAD_BEEF, 10);

    // stray vld while idle
    i_data_vld = 1; i_ld_data = 32'h1234_5678;
    repeat (2) begin
      cyc();
      #1;
      chk("stray_done", 32'({o_m0_done, o_m1_done}), 0);
      chk("stray_rdata0", o_m0_rdata, model_rdata[0]);
      chk("stray_rdata1", o_m1_rdata, model_rdata[1]);
      chk("stray_busy", 32'(o_busy), 0);
    end
    i_data_vld = 0; i_ld_data = 0;

    // m0 load answered in the second WAIT cycle, then a load that times out
    cyc();
    issue(0, 32'h3000, 32'h0, 4'h0, 1'b0, 32'hA5A5_0001, 1'b0, 4);
    wait_done(3, 32'hA5A5_0001, 10);
    issue(0, 32'h7020, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 6);
    wait_done(0, 32'h0, 20);
    chk("timeout_m1_keep", o_m1_rdata, 32'hDEAD_BEEF);

    // reset during WAIT aborts without a done pulse
    issue(1, 32'h4444, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 3);
    void'(sb.pop_back());
    cyc(); i_m1_req = 0;
    cyc(); cyc();
    i_rst = 1;
    #1;
    chk("abort_addr", o_lsu_addr, 32'h0000_F000);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_done", 32'({o_m0_done, o_m1_done}), 0);
    cyc();
    i_rst = 0;
    model_rdata[0] = 0; model_rdata[1] = 0;
    repeat (3) begin
      cyc();
      #1;
      chk("post_abort_done", 32'({o_m0_done, o_m1_done}), 0);
      chk("post_abort_wren", 32'(o_lsu_wren), 0);
    end

    // both requesting continuously from reset: m0, m1, m0, m1
    i_rst = 1;
    cyc();
    i_rst = 0;
    rr_exp.push_back(0); rr_exp.push_back(1); rr_exp.push_back(0); rr_exp.push_back(1);
    i_m0_req = 1; i_m0_addr = 32'h100; i_m0_wdata = 32'h11; i_m0_strb = 4'h1; i_m0_wren = 1;
    i_m1_req = 1; i_m1_addr = 32'h200; i_m1_wdata = 32'h22; i_m1_strb = 4'h2; i_m1_wren = 1;
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (o_m0_gnt || o_m1_gnt) begin
        chk("rr_onehot", 32'(o_m0_gnt & o_m1_gnt), 0);
        chk("rr_order", o_m1_gnt ? 1 : 0, rr_exp.pop_front());
        grants++;
      end
      cyc();
    end
    chk("rr_count", grants, 4);
    idle_inputs();
    repeat (4) cyc();
    #1;
    chk("rr_rdata0", o_m0_rdata, 0);
    chk("rr_rdata1", o_m1_rdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
